// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that configures, runs and services the interval timer slave.
// It counts serviced timeouts and captures 32-bit counter snapshots on request.
module timer_ctrl_master #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
    parameter int          ADDR_W         = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              snap_req,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_write,
    output logic              av_read,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              av_waitrequest,
    input  logic              av_readdatavalid,
    input  logic              timer_irq,
    output logic              busy,
    output logic              running,
    output logic              tick_pulse,
    output logic [31:0]       tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_C_STOP = 4'd1;
    localparam logic [3:0] S_C_PL   = 4'd2;
    localparam logic [3:0] S_C_PH   = 4'd3;
    localparam logic [3:0] S_C_CLR  = 4'd4;
    localparam logic [3:0] S_C_CTRL = 4'd5;
    localparam logic [3:0] S_RUN    = 4'd6;
    localparam logic [3:0] S_ACK    = 4'd7;
    localparam logic [3:0] S_GUARD  = 4'd8;
    localparam logic [3:0] S_S_STOP = 4'd9;
    localparam logic [3:0] S_SN_W   = 4'd10;
    localparam logic [3:0] S_SN_RL  = 4'd11;
    localparam logic [3:0] S_SN_RLD = 4'd12;
    localparam logic [3:0] S_SN_RH  = 4'd13;
    localparam logic [3:0] S_SN_RHD = 4'd14;

    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CONTROL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PL      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PH      = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SNL     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_SNH     = ADDR_W'(5);

    logic [3:0]        state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic              cont_q, cont_d;
    logic              running_q, running_d;
    logic [31:0]       tick_count_q, tick_count_d;
    logic [15:0]       snap_lo_q, snap_lo_d;
    logic [31:0]       snap_value_q, snap_value_d;
    logic              snap_valid_q, snap_valid_d;
    logic              stop_pend_q, stop_pend_d;
    logic              snap_pend_q, snap_pend_d;
    logic              guard_q, guard_d;

    logic              av_write_s, av_read_s, acc_s, start_s;
    logic [ADDR_W-1:0] av_address_s;
    logic [15:0]       av_writedata_s;

    // Bus strobes decode from the registered state only, so reset clears them at once.
    always_comb begin
        av_write_s     = 1'b0;
        av_read_s      = 1'b0;
        av_address_s   = A_STATUS;
        av_writedata_s = 16'h0000;
        case (state_q)
            S_C_STOP, S_S_STOP: begin
                av_write_s = 1'b1; av_address_s = A_CONTROL; av_writedata_s = 16'h0008;
            end
            S_C_PL: begin
                av_write_s = 1'b1; av_address_s = A_PL; av_writedata_s = period_q[15:0];
            end
            S_C_PH: begin
                av_write_s = 1'b1; av_address_s = A_PH; av_writedata_s = period_q[31:16];
            end
            S_C_CLR, S_ACK: begin
                av_write_s = 1'b1; av_address_s = A_STATUS; av_writedata_s = 16'h0000;
            end
            S_C_CTRL: begin
                av_write_s     = 1'b1;
                av_address_s   = A_CONTROL;
                av_writedata_s = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
            end
            S_SN_W: begin
                av_write_s = 1'b1; av_address_s = A_SNL; av_writedata_s = 16'h0000;
            end
            S_SN_RL: begin
                av_read_s = 1'b1; av_address_s = A_SNL;
            end
            S_SN_RH: begin
                av_read_s = 1'b1; av_address_s = A_SNH;
            end
            default: begin
                av_write_s = 1'b0;
            end
        endcase
    end

    assign acc_s   = (av_write_s | av_read_s) & ~av_waitrequest;
    // A pending IRQ beats a restart request in RUN.
    assign start_s = cfg_start & ((state_q == S_IDLE) | ((state_q == S_RUN) & ~timer_irq));

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        running_d    = running_q;
        tick_count_d = tick_count_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        stop_pend_d  = stop_pend_q;
        snap_pend_d  = snap_pend_q;
        guard_d      = guard_q;
        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                snap_pend_d = 1'b0;
            end
            S_C_STOP: if (acc_s) state_d = S_C_PL;  else state_d = S_C_STOP;
            S_C_PL:   if (acc_s) state_d = S_C_PH;  else state_d = S_C_PL;
            S_C_PH:   if (acc_s) state_d = S_C_CLR; else state_d = S_C_PH;
            S_C_CLR:  if (acc_s) state_d = S_C_CTRL; else state_d = S_C_CLR;
            S_C_CTRL: begin
                if (acc_s) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                end else begin
                    state_d = S_C_CTRL;
                end
            end
            S_RUN: begin
                if (timer_irq) begin
                    state_d     = S_ACK;
                    stop_pend_d = stop_pend_q | cfg_stop;
                    snap_pend_d = snap_pend_q | snap_req;
                end else if (cfg_start) begin
                    state_d = S_C_STOP;
                end else if (cfg_stop | stop_pend_q) begin
                    state_d     = S_S_STOP;
                    stop_pend_d = 1'b0;
                    snap_pend_d = snap_pend_q | snap_req;
                end else if (snap_req | snap_pend_q) begin
                    state_d     = S_SN_W;
                    snap_pend_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_ACK: begin
                if (acc_s) begin
                    tick_count_d = tick_count_q + 32'd1;
                    guard_d      = 1'b0;
                    state_d      = S_GUARD;
                end else begin
                    state_d = S_ACK;
                end
            end
            // The slave's irq is still high for one cycle after the clear is accepted.
            S_GUARD: begin
                if (!guard_q) begin
                    guard_d = 1'b1;
                end else if (cont_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d     = S_IDLE;
                    running_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    snap_pend_d = 1'b0;
                end
            end
            S_S_STOP: begin
                if (acc_s) begin
                    state_d     = S_IDLE;
                    running_d   = 1'b0;
                    snap_pend_d = 1'b0;
                end else begin
                    state_d = S_S_STOP;
                end
            end
            S_SN_W:  if (acc_s) state_d = S_SN_RL;  else state_d = S_SN_W;
            S_SN_RL: if (acc_s) state_d = S_SN_RLD; else state_d = S_SN_RL;
            S_SN_RLD: begin
                if (av_readdatavalid) begin
                    snap_lo_d = av_readdata;
                    state_d   = S_SN_RH;
                end else begin
                    state_d = S_SN_RLD;
                end
            end
            S_SN_RH: if (acc_s) state_d = S_SN_RHD; else state_d = S_SN_RH;
            S_SN_RHD: begin
                if (av_readdatavalid) begin
                    snap_value_d = {av_readdata, snap_lo_q};
                    snap_valid_d = 1'b1;
                    state_d      = S_RUN;
                end else begin
                    state_d = S_SN_RHD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_s) begin
            state_d      = S_C_STOP;
            tick_count_d = 32'd0;
            period_d     = (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;
            cont_d       = cfg_continuous;
            running_d    = 1'b0;
            stop_pend_d  = 1'b0;
            snap_pend_d  = 1'b0;
        end else begin
            cont_d = cont_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            period_q     <= 32'd0;
            cont_q       <= 1'b0;
            running_q    <= 1'b0;
            tick_count_q <= 32'd0;
            snap_lo_q    <= 16'h0000;
            snap_value_q <= 32'd0;
            snap_valid_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            running_q    <= running_d;
            tick_count_q <= tick_count_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            guard_q      <= guard_d;
        end
    end

    assign av_address   = av_address_s;
    assign av_write     = av_write_s;
    assign av_read      = av_read_s;
    assign av_writedata = av_writedata_s;
    assign busy         = (state_q != S_IDLE) && (state_q != S_RUN);
    assign running      = running_q;
    assign tick_pulse   = (state_q == S_ACK) & ~av_waitrequest;
    assign tick_count   = tick_count_q;
    assign snap_value   = snap_value_q;
    assign snap_valid   = snap_valid_q;

endmodule
